// File: rtl/demux_pkg.sv
// Shared types and sizes for the round-robin demux dispatcher.
package demux_pkg;

  localparam int N_OUT = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage : demux_pkg

// File: rtl/demux_rr_dispatcher_if.sv
// Producer/consumer bundle of the dispatcher; the slave modport is the dispatcher side.
interface demux_rr_dispatcher_if #(
  parameter int WIDTH = 2
);
  import demux_pkg::*;

  logic                             in_valid;
  logic                             in_ready;
  logic [WIDTH-1:0]                 in_data;
  sel_t                             in_dest;
  logic                             in_auto;
  logic [N_OUT-1:0]                 out_valid;
  logic [N_OUT-1:0]                 out_ready;
  logic [N_OUT-1:0][WIDTH-1:0]      out_data;
  sel_t                             sel;
  logic [N_OUT-1:0][7:0]            acc_cnt;

  modport master (
    output in_valid, in_data, in_dest, in_auto, out_ready,
    input  in_ready, out_valid, out_data, sel, acc_cnt
  );

  modport slave (
    input  in_valid, in_data, in_dest, in_auto, out_ready,
    output in_ready, out_valid, out_data, sel, acc_cnt
  );

endinterface : demux_rr_dispatcher_if

// File: rtl/rr_pick.sv
// Rotate-and-find-first-set: returns the first requesting index at or after ptr_i, wrapping mod 4.
module rr_pick
  import demux_pkg::*;
(
  input  logic [N_OUT-1:0] req_i,
  input  sel_t             ptr_i,
  output sel_t             gnt_idx_o,
  output logic             any_o
);

  sel_t cand;

  // Scan from the farthest offset down so the closest hit to ptr_i wins.
  always_comb begin
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = '0;
    for (int k = N_OUT - 1; k >= 0; k--) begin
      cand = ptr_i + sel_t'(k);
      if (req_i[cand]) begin
        any_o     = 1'b1;
        gnt_idx_o = cand;
      end
    end
  end

endmodule : rr_pick

// File: rtl/demux_rr_dispatcher.sv
// 1-to-4 demux with single-slot registered channels; target is in_dest or the next free channel round-robin.
module demux_rr_dispatcher
  import demux_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux_rr_dispatcher_if.slave  bus
);

  slot_state_t                 slot_q [N_OUT];
  logic [N_OUT-1:0][WIDTH-1:0] data_q;
  logic [N_OUT-1:0][7:0]       cnt_q;
  sel_t                        sel_q, sel_d;
  sel_t                        rrPtr_q, rrPtr_d;

  logic [N_OUT-1:0] freeMask;
  logic [N_OUT-1:0] writeEn;
  sel_t             rrGnt;
  logic             rrAny;
  sel_t             target;
  logic             accept;

  // A full slot counts as free when its consumer drains it this cycle.
  always_comb begin
    freeMask = '0;
    for (int i = 0; i < N_OUT; i++) begin
      freeMask[i] = (slot_q[i] == EMPTY) || bus.out_ready[i];
    end
  end

  rr_pick u_rr_pick (
    .req_i     (freeMask),
    .ptr_i     (rrPtr_q),
    .gnt_idx_o (rrGnt),
    .any_o     (rrAny)
  );

  assign target       = bus.in_auto ? rrGnt : bus.in_dest;
  assign bus.in_ready = bus.in_auto ? rrAny : freeMask[bus.in_dest];
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    writeEn = '0;
    sel_d   = sel_q;
    rrPtr_d = rrPtr_q;
    if (accept) begin
      writeEn[target] = 1'b1;
      sel_d           = target;
      if (bus.in_auto) begin
        rrPtr_d = target + sel_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OUT; i++) begin
        slot_q[i] <= EMPTY;
      end
      data_q  <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      rrPtr_q <= '0;
    end else begin
      sel_q   <= sel_d;
      rrPtr_q <= rrPtr_d;
      for (int i = 0; i < N_OUT; i++) begin
        case (slot_q[i])
          EMPTY: begin
            if (writeEn[i]) begin
              slot_q[i] <= FULL;
            end
          end
          FULL: begin
            if (!writeEn[i] && bus.out_ready[i]) begin
              slot_q[i] <= EMPTY;
            end
          end
          default: slot_q[i] <= EMPTY;
        endcase
        if (writeEn[i]) begin
          data_q[i] <= bus.in_data;
          cnt_q[i]  <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    bus.out_valid = '0;
    for (int i = 0; i < N_OUT; i++) begin
      bus.out_valid[i] = (slot_q[i] == FULL);
    end
  end

  assign bus.out_data = data_q;
  assign bus.acc_cnt  = cnt_q;
  assign bus.sel      = sel_q;

endmodule : demux_rr_dispatcher

// File: tb/tb_demux_rr_dispatcher.sv
// Directed bench for demux_rr_dispatcher with hand-computed expectations.
module tb_demux_rr_dispatcher;

  logic clk;
  logic rst_n;
  int   testCount;
  int   failCount;

  demux_rr_dispatcher_if #(.WIDTH(2)) bus ();

  demux_rr_dispatcher #(.WIDTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [1:0] d, input logic [1:0] dest,
                               input logic auto, input logic [3:0] rdy);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_dest   = dest;
    bus.in_auto   = auto;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 4'h0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  logic [1:0] t2Words [5];
  logic [1:0] t3Words [4];

  initial begin
    testCount = 0;
    failCount = 0;
    t2Words = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
    t3Words = '{2'd1, 2'd2, 2'd3, 2'd0};

    // Reset held while the producer offers a word
    rst_n = 1'b0;
    applyStimulus(1'b1, 2'd3, 2'd0, 1'b1, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", bus.out_valid, 32'h0);
    checkOutput("rst_sel", bus.sel, 32'h0);
    checkOutput("rst_acc0", bus.acc_cnt[0], 32'h0);
    checkOutput("rst_data0", bus.out_data[0], 32'h0);
    rst_n = 1'b1;
    step();
    checkOutput("rel_out_valid", bus.out_valid, 32'h1);
    checkOutput("rel_data0", bus.out_data[0], 32'h3);
    checkOutput("rel_acc0", bus.acc_cnt[0], 32'h1);

    // Auto mode, everything drained each cycle
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, t2Words[i], 2'd0, 1'b1, 4'hF);
      checkOutput("t2_in_ready", bus.in_ready, 32'h1);
      step();
      checkOutput("t2_sel", bus.sel, 32'(i % 4));
      checkOutput("t2_data", bus.out_data[i % 4], 32'(t2Words[i]));
      checkOutput("t2_out_valid", bus.out_valid, 32'(1) << (i % 4));
    end
    checkOutput("t2_acc0", bus.acc_cnt[0], 32'd2);
    checkOutput("t2_acc3", bus.acc_cnt[3], 32'd1);

    // Auto mode, no drains: fill all four then stall
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, t3Words[i], 2'd0, 1'b1, 4'h0);
      checkOutput("t3_in_ready", bus.in_ready, 32'h1);
      step();
    end
    checkOutput("t3_full", bus.out_valid, 32'hF);
    applyStimulus(1'b1, 2'd2, 2'd0, 1'b1, 4'h0);
    checkOutput("t3_stall_ready", bus.in_ready, 32'h0);
    step();
    checkOutput("t3_stall_acc0", bus.acc_cnt[0], 32'd1);
    checkOutput("t3_stall_data2", bus.out_data[2], 32'd3);
    applyStimulus(1'b1, 2'd2, 2'd0, 1'b1, 4'b0100);
    checkOutput("t3_drain_ready", bus.in_ready, 32'h1);
    step();
    checkOutput("t3_sel", bus.sel, 32'd2);
    checkOutput("t3_data2", bus.out_data[2], 32'd2);
    checkOutput("t3_data0", bus.out_data[0], 32'd1);
    checkOutput("t3_out_valid", bus.out_valid, 32'hF);
    checkOutput("t3_acc2", bus.acc_cnt[2], 32'd2);

    // Explicit mode against a full channel, then drain-and-refill
    applyStimulus(1'b1, 2'd1, 2'd2, 1'b0, 4'h0);
    checkOutput("t4_blocked", bus.in_ready, 32'h0);
    step();
    checkOutput("t4_hold_data2", bus.out_data[2], 32'd2);
    checkOutput("t4_hold_valid", bus.out_valid, 32'hF);
    applyStimulus(1'b1, 2'd1, 2'd0, 1'b0, 4'b0100);
    checkOutput("t4_dest0_blocked", bus.in_ready, 32'h0);
    applyStimulus(1'b1, 2'd1, 2'd2, 1'b0, 4'b0100);
    checkOutput("t4_refill_ready", bus.in_ready, 32'h1);
    step();
    checkOutput("t4_data2", bus.out_data[2], 32'd1);
    checkOutput("t4_out_valid", bus.out_valid, 32'hF);
    checkOutput("t4_sel", bus.sel, 32'd2);
    checkOutput("t4_acc2", bus.acc_cnt[2], 32'd3);

    // Explicit mode counter wrap on channel 1; round-robin pointer untouched
    doReset();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 2'(i), 2'd1, 1'b0, 4'hF);
      step();
      if (i == 254) checkOutput("t5_acc1_255", bus.acc_cnt[1], 32'd255);
    end
    checkOutput("t5_acc1_wrap", bus.acc_cnt[1], 32'd0);
    checkOutput("t5_data1", bus.out_data[1], 32'd3);
    checkOutput("t5_sel", bus.sel, 32'd1);
    applyStimulus(1'b1, 2'd2, 2'd0, 1'b1, 4'hF);
    step();
    checkOutput("t5_auto_sel", bus.sel, 32'd0);
    checkOutput("t5_auto_data0", bus.out_data[0], 32'd2);
    checkOutput("t5_auto_acc0", bus.acc_cnt[0], 32'd1);

    // Asynchronous reset mid-stream
    doReset();
    applyStimulus(1'b1, 2'd1, 2'd1, 1'b0, 4'h0);
    step();
    applyStimulus(1'b1, 2'd2, 2'd3, 1'b0, 4'h0);
    step();
    checkOutput("t6_pre_valid", bus.out_valid, 32'hA);
    applyStimulus(1'b0, 2'd0, 2'd0, 1'b0, 4'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_async_valid", bus.out_valid, 32'h0);
    checkOutput("t6_async_acc1", bus.acc_cnt[1], 32'h0);
    checkOutput("t6_async_acc3", bus.acc_cnt[3], 32'h0);
    checkOutput("t6_async_data3", bus.out_data[3], 32'h0);
    #1;
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule : tb_demux_rr_dispatcher
